// File: rtl/fan_speed_controller.sv
// Fan sequencer. It synchronises the 1 kHz clock and the buttons, and runs the
// OFF/LOW/MID/HIGH mode FSM, a tick-driven PWM and an auto-off countdown timer.
module fan_speed_controller #(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned PWM_STEPS     = 10,
  parameter int unsigned DUTY_LOW      = 3,
  parameter int unsigned DUTY_MID      = 6,
  parameter int unsigned DUTY_HIGH     = 9,
  parameter int unsigned PRESET1       = 60,
  parameter int unsigned PRESET2       = 180,
  parameter int unsigned PRESET3       = 300
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_1khz,
  input  logic        i_btn_mode,
  input  logic        i_btn_off,
  input  logic        i_btn_timer,
  output logic        o_pwm,
  output logic [1:0]  o_mode,
  output logic [1:0]  o_timer_sel,
  output logic [15:0] o_remain_sec,
  output logic        o_tick
);

  localparam int unsigned CW = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
  localparam int unsigned DW = CW + 1;
  localparam int unsigned MW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [CW-1:0] CntLast = CW'(PWM_STEPS - 1);
  localparam logic [MW-1:0] MsLast  = MW'(TICKS_PER_SEC - 1);
  // A duty at or above the period is clamped to PWM_STEPS, so the output stays high.
  localparam logic [DW-1:0] DutyLow  = (DUTY_LOW >= PWM_STEPS) ? DW'(PWM_STEPS) : DW'(DUTY_LOW);
  localparam logic [DW-1:0] DutyMid  = (DUTY_MID >= PWM_STEPS) ? DW'(PWM_STEPS) : DW'(DUTY_MID);
  localparam logic [DW-1:0] DutyHigh = (DUTY_HIGH >= PWM_STEPS) ? DW'(PWM_STEPS) : DW'(DUTY_HIGH);

  if (PRESET1 > 65535 || PRESET2 > 65535 || PRESET3 > 65535) begin : g_preset_range
    $error("fan_speed_controller: auto-off presets must be below 65536");
  end

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StLow  = 2'd1,
    StMid  = 2'd2,
    StHigh = 2'd3
  } mode_e;

  function automatic logic [DW-1:0] duty_for(mode_e m);
    case (m)
      StLow:   duty_for = DutyLow;
      StMid:   duty_for = DutyMid;
      StHigh:  duty_for = DutyHigh;
      default: duty_for = '0;
    endcase
  endfunction

  function automatic logic [15:0] preset_for(logic [1:0] sel);
    case (sel)
      2'd1:    preset_for = 16'(PRESET1);
      2'd2:    preset_for = 16'(PRESET2);
      2'd3:    preset_for = 16'(PRESET3);
      default: preset_for = 16'd0;
    endcase
  endfunction

  // Bit 0: 1 kHz clock, bit 1: mode, bit 2: off, bit 3: timer.
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, ev;
  logic       tick, ev_mode, ev_off, ev_timer, expire;

  mode_e          mode_q, mode_d;
  logic [1:0]     sel_q, sel_d;
  logic [15:0]    remain_q, remain_d;
  logic [MW-1:0]  ms_q, ms_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  duty_q, duty_d;
  logic           pwm_q, pwm_d;

  always_comb begin
    sync1_d = {i_btn_timer, i_btn_off, i_btn_mode, i_clk_1khz};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  assign ev       = sync2_q & ~prev_q;
  assign tick     = ev[0];
  assign ev_mode  = ev[1];
  assign ev_off   = ev[2];
  assign ev_timer = ev[3];

  // Mode FSM and auto-off timer.
  always_comb begin
    mode_d   = mode_q;
    sel_d    = sel_q;
    remain_d = remain_q;
    ms_d     = ms_q;
    expire   = 1'b0;

    if (tick && (sel_q != 2'd0)) begin
      if (ms_q == MsLast) begin
        ms_d = '0;
        if (remain_q <= 16'd1) begin
          expire = 1'b1;
        end else begin
          remain_d = remain_q - 16'd1;
        end
      end else begin
        ms_d = ms_q + MW'(1);
      end
    end

    if (ev_off || expire) begin
      mode_d   = StOff;
      sel_d    = 2'd0;
      remain_d = 16'd0;
      ms_d     = '0;
    end else begin
      if (ev_mode) begin
        unique case (mode_q)
          StOff: begin
            mode_d   = StLow;
            sel_d    = 2'd0;
            remain_d = 16'd0;
            ms_d     = '0;
          end
          StLow:  mode_d = StMid;
          StMid:  mode_d = StHigh;
          StHigh: mode_d = StLow;
        endcase
      end
      // Judged against the mode before this update, so a press from OFF is ignored.
      if (ev_timer && (mode_q != StOff)) begin
        sel_d    = sel_q + 2'd1;
        remain_d = preset_for(sel_d);
        ms_d     = '0;
      end
    end
  end

  // PWM: the duty only changes at a period start, except that OFF clears it at once.
  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (tick) begin
      if (cnt_q == CntLast) begin
        cnt_d  = '0;
        duty_d = duty_for(mode_d);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (mode_d == StOff) begin
      duty_d = '0;
    end
    pwm_d = (mode_d != StOff) && ({1'b0, cnt_d} < duty_d);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      mode_q   <= StOff;
      sel_q    <= 2'd0;
      remain_q <= 16'd0;
      ms_q     <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      remain_q <= remain_d;
      ms_q     <= ms_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
    end
  end

  assign o_pwm        = pwm_q;
  assign o_mode       = mode_q;
  assign o_timer_sel  = sel_q;
  assign o_remain_sec = remain_q;
  assign o_tick       = tick;

endmodule

// File: tb/tb_fan_speed_controller.sv
// Scoreboard bench for fan_speed_controller: stimulus queues expected values per cycle,
// a monitor compares them on the falling clock edge.
module tb_fan_speed_controller;

  localparam int SigMode = 0;
  localparam int SigSel  = 1;
  localparam int SigRem  = 2;
  localparam int SigPwm  = 3;
  localparam int SigTick = 4;

  logic        i_clk       = 1'b0;
  logic        i_reset     = 1'b1;
  logic        i_clk_1khz  = 1'b0;
  logic        i_btn_mode  = 1'b0;
  logic        i_btn_off   = 1'b0;
  logic        i_btn_timer = 1'b0;
  logic        o_pwm;
  logic [1:0]  o_mode;
  logic [1:0]  o_timer_sel;
  logic [15:0] o_remain_sec;
  logic        o_tick;

  int    q_cyc[$];
  int    q_sig[$];
  int    q_val[$];
  string q_name[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;

  fan_speed_controller #(
    .TICKS_PER_SEC(4),
    .PWM_STEPS    (10),
    .DUTY_LOW     (3),
    .DUTY_MID     (6),
    .DUTY_HIGH    (9),
    .PRESET1      (3),
    .PRESET2      (5),
    .PRESET3      (7)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clk_1khz  (i_clk_1khz),
    .i_btn_mode  (i_btn_mode),
    .i_btn_off   (i_btn_off),
    .i_btn_timer (i_btn_timer),
    .o_pwm       (o_pwm),
    .o_mode      (o_mode),
    .o_timer_sel (o_timer_sel),
    .o_remain_sec(o_remain_sec),
    .o_tick      (o_tick)
  );

  initial forever #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // 20-cycle divided clock; rises on the falling edge where cyc % 20 == 10.
  initial forever begin
    @(negedge i_clk);
    i_clk_1khz = ((cyc % 20) >= 10);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic expect_at(input int c, input int sig, input int val, input string name);
    q_cyc.push_back(c);
    q_sig.push_back(sig);
    q_val.push_back(val);
    q_name.push_back(name);
  endtask

  task automatic expect_state(input int c, input int m, input int s, input int r,
                              input string name);
    expect_at(c, SigMode, m, {name, "_mode"});
    expect_at(c, SigSel, s, {name, "_sel"});
    expect_at(c, SigRem, r, {name, "_remain"});
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge i_clk);
  endtask

  task automatic press(input logic m, input logic o, input logic t, input int hold);
    i_btn_mode  = m;
    i_btn_off   = o;
    i_btn_timer = t;
    repeat (hold) @(negedge i_clk);
    i_btn_mode  = 1'b0;
    i_btn_off   = 1'b0;
    i_btn_timer = 1'b0;
  endtask

  // Monitor: pops every expectation due this cycle and compares it with the outputs.
  initial begin
    int act;
    forever begin
      @(negedge i_clk);
      for (int i = q_cyc.size() - 1; i >= 0; i--) begin
        if (q_cyc[i] == cyc) begin
          case (q_sig[i])
            SigMode: act = int'(o_mode);
            SigSel:  act = int'(o_timer_sel);
            SigRem:  act = int'(o_remain_sec);
            SigPwm:  act = int'(o_pwm);
            default: act = int'(o_tick);
          endcase
          n_cmp++;
          if (act != q_val[i]) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", q_name[i], cyc, act,
                     q_val[i]);
          end
          q_cyc.delete(i);
          q_sig.delete(i);
          q_val.delete(i);
          q_name.delete(i);
        end
      end
    end
  end

  initial begin
    int mode_before[4] = '{0, 1, 2, 3};
    int mode_after[4]  = '{1, 2, 3, 1};
    int sel_seq[4]     = '{1, 2, 3, 0};
    int rem_seq[4]     = '{3, 5, 7, 0};
    int r;

    // Reset and mode stepping; ticks at cycles 12 + 20m.
    expect_state(1, 0, 0, 0, "rst");
    expect_at(1, SigPwm, 0, "rst_pwm");
    expect_at(1, SigTick, 0, "rst_tick");
    expect_at(12, SigTick, 1, "tick_first");
    expect_at(13, SigTick, 0, "tick_one_cycle");
    expect_at(31, SigTick, 0, "tick_gap");
    expect_at(32, SigTick, 1, "tick_period20_a");
    expect_at(52, SigTick, 1, "tick_period20_b");
    at(2);
    n_cmp++;
    if (o_mode != 2'd0 || o_pwm != 1'b0 || o_timer_sel != 2'd0 || o_remain_sec != 16'd0) begin
      n_bad++;
      $display("FAIL direct_rst: outputs not zero during reset");
    end
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_at(22 + 20 * i, SigMode, mode_before[i], "mode_latency_pre");
      expect_at(23 + 20 * i, SigMode, mode_after[i], "mode_step");
      at(20 + 20 * i);
      press(1'b1, 1'b0, 1'b0, 4);
    end
    expect_at(103, SigMode, 2, "held_step");
    expect_at(150, SigMode, 2, "held_no_repeat");
    expect_at(199, SigMode, 2, "held_late");
    expect_at(205, SigMode, 2, "held_released");
    at(100);
    press(1'b1, 1'b0, 1'b0, 100);

    // LOW steady state, then HIGH requested mid-period.
    at(210);
    i_reset = 1'b1;
    at(222);
    i_reset = 1'b0;
    r = 222;
    expect_at(r + 6, SigMode, 1, "low_mode");
    expect_at(r + 10, SigTick, 1, "tick_after_rst");
    expect_at(r + 30, SigTick, 1, "tick_after_rst_next");
    expect_at(r + 50, SigPwm, 0, "pwm_low_wait_a");
    expect_at(r + 190, SigPwm, 0, "pwm_low_wait_b");
    expect_at(r + 191, SigPwm, 1, "pwm_low_period_start");
    expect_at(r + 444, SigMode, 3, "high_mode");
    for (int k = 0; k < 10; k++) begin
      expect_at(r + 201 + 20 * k, SigPwm, (k < 3) ? 1 : 0, "pwm_low_p1");
      expect_at(r + 401 + 20 * k, SigPwm, (k < 3) ? 1 : 0, "pwm_old_duty_p2");
      expect_at(r + 601 + 20 * k, SigPwm, (k < 9) ? 1 : 0, "pwm_high_p3");
    end
    at(r + 3);
    press(1'b1, 1'b0, 1'b0, 4);
    at(r + 420);
    press(1'b1, 1'b0, 1'b0, 4);
    at(r + 440);
    press(1'b1, 1'b0, 1'b0, 4);

    // MID with PRESET1 countdown; a mode press lands on the expiry cycle.
    at(1030);
    i_reset = 1'b1;
    at(1042);
    i_reset = 1'b0;
    r = 1042;
    expect_state(r + 26, 2, 0, 0, "mid_no_timer");
    expect_at(r + 45, SigSel, 0, "timer_latency_pre");
    expect_state(r + 46, 2, 1, 3, "timer_p1");
    expect_at(r + 110, SigRem, 3, "remain_hold");
    expect_at(r + 111, SigRem, 2, "remain_dec_a");
    expect_at(r + 191, SigRem, 1, "remain_dec_b");
    expect_at(r + 260, SigPwm, 1, "pwm_mid_before_expiry");
    expect_state(r + 270, 2, 1, 1, "pre_expiry");
    expect_state(r + 271, 0, 0, 0, "expiry");
    expect_at(r + 271, SigPwm, 0, "expiry_pwm");
    expect_at(r + 300, SigMode, 0, "expiry_stays_off");
    expect_at(r + 300, SigPwm, 0, "expiry_pwm_stays_0");
    at(r + 3);
    press(1'b1, 1'b0, 1'b0, 4);
    at(r + 23);
    press(1'b1, 1'b0, 1'b0, 4);
    at(r + 43);
    press(1'b0, 1'b0, 1'b1, 4);
    at(r + 268);
    press(1'b1, 1'b0, 1'b0, 4);

    // Timer in OFF, preset cycling, simultaneous presses, async reset.
    at(1400);
    i_reset = 1'b1;
    at(1422);
    i_reset = 1'b0;
    r = 1422;
    expect_state(r + 6, 0, 0, 0, "timer_in_off");
    expect_at(r + 26, SigMode, 1, "low_again");
    for (int i = 0; i < 4; i++) begin
      expect_at(r + 46 + 20 * i, SigSel, sel_seq[i], "sel_cycle");
      expect_at(r + 46 + 20 * i, SigRem, rem_seq[i], "remain_load");
    end
    expect_at(r + 106, SigMode, 1, "mode_kept_by_timer");
    expect_state(r + 116, 1, 1, 3, "timer_rearm");
    expect_state(r + 126, 0, 0, 0, "off_beats_mode");
    expect_state(r + 146, 1, 0, 0, "leave_off_sel0");
    expect_state(r + 166, 2, 1, 3, "mode_and_timer");
    expect_state(r + 200, 2, 1, 3, "pre_async_rst");
    expect_at(r + 200, SigPwm, 1, "pre_async_rst_pwm");
    expect_state(r + 201, 0, 0, 0, "async_rst");
    expect_at(r + 201, SigPwm, 0, "async_rst_pwm");
    expect_at(r + 201, SigTick, 0, "async_rst_tick");
    expect_state(r + 225, 0, 0, 0, "post_rst");
    expect_at(r + 225, SigPwm, 0, "post_rst_pwm");
    at(r + 3);
    press(1'b0, 1'b0, 1'b1, 4);
    at(r + 23);
    press(1'b1, 1'b0, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      at(r + 43 + 20 * i);
      press(1'b0, 1'b0, 1'b1, 4);
    end
    at(r + 113);
    press(1'b0, 1'b0, 1'b1, 4);
    at(r + 123);
    press(1'b1, 1'b1, 1'b0, 4);
    at(r + 143);
    press(1'b1, 1'b0, 1'b0, 4);
    at(r + 163);
    press(1'b1, 1'b0, 1'b1, 4);
    at(r + 200);
    @(posedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    n_cmp++;
    if (o_pwm != 1'b0) begin
      n_bad++;
      $display("FAIL direct_async_pwm: o_pwm=%0d before next edge", o_pwm);
    end
    n_cmp++;
    if (o_mode != 2'd0 || o_timer_sel != 2'd0 || o_remain_sec != 16'd0) begin
      n_bad++;
      $display("FAIL direct_async_state: mode=%0d sel=%0d remain=%0d before next edge", o_mode,
               o_timer_sel, o_remain_sec);
    end
    at(r + 220);
    i_reset = 1'b0;
    at(r + 240);
    n_cmp++;
    if (o_mode != 2'd0) begin
      n_bad++;
      $display("FAIL direct_end_mode: got %0d, expected 0", o_mode);
    end
    n_cmp++;
    if (o_pwm != 1'b0) begin
      n_bad++;
      $display("FAIL direct_end_pwm: got %0d, expected 0", o_pwm);
    end

    for (int i = 0; i < q_cyc.size(); i++) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expected %0d at cycle %0d was never compared", q_name[i], q_val[i],
               q_cyc[i]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fan_speed_controller.md
Name: fan_speed_controller

Overview:
- Top-level sequencer for the fan datapath: consumes the 1 kHz divided clock, generates a 1 ms enable tick, and runs the fan-mode FSM (OFF/LOW/MID/HIGH).
- Drives a tick-based PWM output and an auto-off countdown timer.
- Sits between the debounced button inputs and the fan/LED driver pins.

Parameters:
- TICKS_PER_SEC, 1000, 1 ms ticks per timer second.
- PWM_STEPS, 10, PWM period in ticks (counter width = clog2(PWM_STEPS)).
- DUTY_LOW, 3, high ticks per period in LOW.
- DUTY_MID, 6, high ticks per period in MID.
- DUTY_HIGH, 9, high ticks per period in HIGH.
- PRESET1 / PRESET2 / PRESET3, 60 / 180 / 300, auto-off presets in seconds.

Ports:
- i_clk  in  1  system clock (100 MHz)
- i_reset  in  1  reset
- i_clk_1khz  in  1  1 kHz, 50% duty divided clock; treated as asynchronous data
- i_btn_mode  in  1  debounced level; press = rising edge
- i_btn_off  in  1  debounced level; press = rising edge
- i_btn_timer  in  1  debounced level; press = rising edge
- o_pwm  out  1  fan PWM
- o_mode  out  2  0=OFF, 1=LOW, 2=MID, 3=HIGH
- o_timer_sel  out  2  0=none, 1..3=PRESET1..3
- o_remain_sec  out  16  seconds remaining; 0 when sel=0
- o_tick  out  1  1-cycle 1 ms enable, for debug

Behaviour:
- Reset: i_reset, asynchronous, active-high; clock i_clk. All outputs and internal registers 0 (o_mode=OFF, o_pwm=0). Reset mid-operation aborts timer/PWM immediately.
- Input synchronisation:
  - Each of i_clk_1khz and the three buttons passes through 2 flops plus a previous-value flop; event = sync2 & ~prev.
  - Latency: an input rising before i_clk edge k produces the event during cycle k+2; the state update is visible after edge k+3.
  - o_tick = the i_clk_1khz event, exactly 1 cycle per 1 kHz period.
  - Held buttons produce one event only.
- Mode FSM, transitions on events:
  - mode press: OFF->LOW->MID->HIGH->LOW.
  - off press: any->OFF, clears timer.
  - timer expiry: any->OFF, clears timer.
  - Priority: off press = expiry > mode press.
  - mode and timer presses in the same cycle both take effect.
- Timer:
  - timer press ignored in OFF.
  - Otherwise sel cycles 0->1->2->3->0. o_remain_sec is loaded with the new preset (0 for sel=0) and the ms counter is cleared.
  - ms counter advances on tick while sel!=0. At TICKS_PER_SEC-1 it wraps to 0 and o_remain_sec decrements.
  - Decrement from 1 to 0 = expiry: in the same update, mode=OFF, sel=0, remain=0.
  - Leaving OFF via mode press starts with sel=0.
- PWM:
  - Period counter 0..PWM_STEPS-1 advances on tick and wraps, running in all modes.
  - Duty register latches the duty for the current mode when the counter wraps to 0 (glitch-free change).
  - o_pwm = (mode!=OFF) & (cnt < duty_reg), registered.
  - Entering OFF forces o_pwm=0 on the next cycle and duty_reg=0.
  - OFF->LOW: pwm stays 0 until the next period start.
  - Duty >= PWM_STEPS gives constant high.
- Widths: o_remain_sec saturates at its 16-bit range. Presets must be < 65536, checked at elaboration.

Test Plan:
(Bench params: TICKS_PER_SEC=4, PWM_STEPS=10, presets 3/5/7; i_clk_1khz modelled as a 20-cycle period.)
- Reset then 3 mode presses -> o_mode 1,2,3, each visible 3 cycles after the button edge. 4th press -> 1. Button held 100 cycles -> one step only.
- LOW steady state -> o_pwm high exactly 3 of every 10 ticks. Switch to HIGH mid-period -> 9/10 only from the next period start. o_tick period = 20 cycles.
- MID, timer press x1 -> sel=1, remain=3. After 12 ticks -> mode=0, sel=0, remain=0, o_pwm=0.
- Timer press in OFF -> no change. Timer presses x4 in LOW -> sel 1,2,3,0 with remain 3,5,7,0.
- Off press and mode press in the same cycle -> OFF. Mode press on the expiry cycle -> OFF.
- Assert i_reset asynchronously mid-countdown with pwm high -> all outputs 0 immediately, before the next clock edge.
